// File: rtl/alu_serial.sv
// Multi-cycle N-bit ALU: a DIGIT-wide slice datapath walks the operands LSB first.
// R and flags update only when the last digit retires; SLT bit 0 is resolved at that point.
module alu_serial #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ainv,
   input  logic             Binv,
   input  logic [1:0]       Op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] R,
   output logic             Zero,
   output logic             Cout,
   output logic             Overflow,
   output logic             Set
);

   localparam int unsigned N = WIDTH / DIGIT;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;
   logic   load, step, last;

   logic [WIDTH-1:0] a_q, b_q, r_sh_q;
   logic             ainv_q, binv_q, carry_q;
   logic [1:0]       op_q;
   logic [CntW-1:0]  cnt_q;

   logic [WIDTH-1:0] r_q;
   logic             zero_q, cout_q, ovf_q, set_q;

   logic [DIGIT-1:0]       digit_r;
   logic                   c, ap, bp, s;
   logic                   carry_nx, cin_msb, sum_msb;
   logic                   ovf_d, set_d;
   logic [WIDTH+DIGIT-1:0] r_cat;
   logic [WIDTH-1:0]       r_shifted, r_final;

   assign last = (cnt_q == LastCnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // DONE accepts start exactly like IDLE so operations can run back to back.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               load    = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            step = 1'b1;
            if (last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (start) begin
               load    = 1'b1;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // One digit of slices; the adder chain runs for every Op so the flags are always valid.
   always_comb begin
      c       = carry_q;
      digit_r = '0;
      cin_msb = 1'b0;
      sum_msb = 1'b0;
      ap      = 1'b0;
      bp      = 1'b0;
      s       = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         ap      = a_q[i] ^ ainv_q;
         bp      = b_q[i] ^ binv_q;
         s       = ap ^ bp ^ c;
         cin_msb = c;
         sum_msb = s;
         c       = (ap & bp) | (c & (ap | bp));
         case (op_q)
            2'b00:   digit_r[i] = ap & bp;
            2'b01:   digit_r[i] = ap | bp;
            default: digit_r[i] = s;
         endcase
      end
      carry_nx = c;
   end

   always_comb begin
      ovf_d     = cin_msb ^ carry_nx;
      set_d     = sum_msb ^ ovf_d;
      r_cat     = {digit_r, r_sh_q} >> DIGIT;
      r_shifted = r_cat[WIDTH-1:0];
      if (op_q == 2'b11) begin
         r_final = {{(WIDTH-1){1'b0}}, set_d};
      end else begin
         r_final = r_shifted;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         r_sh_q  <= '0;
         ainv_q  <= 1'b0;
         binv_q  <= 1'b0;
         op_q    <= 2'b00;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         r_q     <= '0;
         zero_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         set_q   <= 1'b0;
      end else if (load) begin
         a_q     <= A;
         b_q     <= B;
         r_sh_q  <= '0;
         ainv_q  <= Ainv;
         binv_q  <= Binv;
         op_q    <= Op;
         carry_q <= Binv;
         cnt_q   <= '0;
      end else if (step) begin
         a_q     <= a_q >> DIGIT;
         b_q     <= b_q >> DIGIT;
         r_sh_q  <= r_shifted;
         carry_q <= carry_nx;
         cnt_q   <= cnt_q + 1'b1;
         if (last) begin
            r_q    <= r_final;
            zero_q <= ~|r_final;
            cout_q <= carry_nx;
            ovf_q  <= ovf_d;
            set_q  <= set_d;
         end
      end
   end

   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign R        = r_q;
   assign Zero     = zero_q;
   assign Cout     = cout_q;
   assign Overflow = ovf_q;
   assign Set      = set_q;

endmodule
